// File: rtl/fetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
package fetch_pkg;

   localparam int          OP_MSB    = 31;
   localparam int          OP_LSB    = 26;
   localparam int          VEC_BIT   = 25;
   localparam logic [5:0]  NOP_OP    = 6'b111111;
   localparam logic [31:0] NOP_INSTR = {NOP_OP, 26'd0};

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   function automatic logic [5:0] op_field(input logic [31:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_if;

   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        valid;

   modport master (output req, addr, input rdata, valid);
   modport slave  (input req, addr, output rdata, valid);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word that arrives while decode is stalled.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] data_i,
   input  logic [31:0] pc_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic [31:0] pc_o
);

   logic        valid_q;
   logic [31:0] data_q;
   logic [31:0] pc_q;

   // Clear wins over load so a redirect always empties the slot.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         valid_q <= 1'b0;
         data_q  <= NOP_INSTR;
         pc_q    <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         pc_q    <= pc_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with skid buffer and redirect kill.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
//
// state  | meaning
// S_REQ  | issue request for pc_q this cycle
// S_WAIT | one request outstanding, waiting for the response pulse
// S_HOLD | response parked in skid buffer until decode releases STALL
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INCR  = 32'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   fetch_if.master     imem,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_killed_o
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         kill_q, kill_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic         instr_valid_q, instr_valid_d;

   logic         skid_load, skid_clear, skid_valid;
   logic [31:0]  skid_data, skid_pc;
   logic         load_out;
   logic [31:0]  load_word, load_pc;

   fetch_skid_buf u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (imem.rdata),
      .pc_i    (pc_q),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .pc_o    (skid_pc)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      kill_d        = kill_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      load_out      = 1'b0;
      load_word     = imem.rdata;
      load_pc       = pc_q;

      if (instr_valid_q && !stall_i) begin
         instr_valid_d = 1'b0;
         instr_d       = NOP_INSTR;
      end

      if (redirect_i) begin
         pc_d          = redirect_pc_i;
         instr_valid_d = 1'b0;
         instr_d       = NOP_INSTR;
         skid_clear    = 1'b1;
         case (state_q)
            S_WAIT: begin
               if (imem.valid) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
               if (imem.valid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (!instr_valid_q || !stall_i) begin
                     load_out = 1'b1;
                  end else begin
                     skid_load = 1'b1;
                     state_d   = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall_i && skid_valid) begin
                  load_out   = 1'b1;
                  load_word  = skid_data;
                  load_pc    = skid_pc;
                  skid_clear = 1'b1;
               end
            end
            default: state_d = S_REQ;
         endcase
      end

      if (load_out) begin
         instr_d       = load_word;
         instr_pc_d    = load_pc;
         instr_valid_d = 1'b1;
         pc_d          = pc_q + PC_INCR;
         state_d       = S_REQ;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         kill_q        <= 1'b0;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         kill_q        <= kill_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // A redirect in S_REQ suppresses the request so no orphan response can appear.
   assign imem.req      = (state_q == S_REQ) & ~redirect_i & ~rst_i;
   assign imem.addr     = rst_i ? RESET_PC : pc_q;
   assign instr_o       = rst_i ? NOP_INSTR : instr_q;
   assign instr_pc_o    = rst_i ? 32'd0 : instr_pc_q;
   assign instr_valid_o = instr_valid_q & ~rst_i;

`ifdef FETCH_PERF_CNT_EN
   logic        word_killed;
   logic [31:0] perf_fetched_q, perf_killed_q;

   assign word_killed = ((state_q == S_WAIT) && imem.valid && (redirect_i || kill_q)) ||
                        ((state_q == S_HOLD) && redirect_i && skid_valid);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_fetched_q <= '0;
         perf_killed_q  <= '0;
      end else begin
         if (load_out)    perf_fetched_q <= perf_fetched_q + 32'd1;
         if (word_killed) perf_killed_q  <= perf_killed_q + 32'd1;
      end
   end

   assign perf_fetched_o = perf_fetched_q;
   assign perf_killed_o  = perf_killed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] INCR = 32'd4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr, instr_pc, instr2, instr_pc2;
   logic        instr_valid, instr_valid2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_f, perf_k, perf_f2, perf_k2;
`endif

   fetch_if imem_if ();
   fetch_if imem_if2 ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INCR(INCR)) dut (
      .clk_i(clk), .rst_i(rst), .imem(imem_if),
      .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(instr_valid)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched_o(perf_f), .perf_killed_o(perf_k)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INCR(INCR)) dut2 (
      .clk_i(clk), .rst_i(rst), .imem(imem_if2),
      .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .instr_o(instr2), .instr_pc_o(instr_pc2), .instr_valid_o(instr_valid2)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched_o(perf_f2), .perf_killed_o(perf_k2)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // memory responder state
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_addr;
   int          mem_lat;
   bit          last_req2;
   logic [31:0] last_addr2;
   logic [31:0] q2[$];

   // values observed during the most recent cycle
   logic        s_req, s_ivalid, s2_ivalid, proto_err;
   logic [31:0] s_addr, s_instr, s_ipc, s2_instr, s2_ipc;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic drive_cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit r);
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      rst         = r;
      proto_err   = 1'b0;
      if (pend && pend_cnt == 0) begin
         imem_if.valid = 1'b1;
         imem_if.rdata = word_at(pend_addr);
         pend          = 1'b0;
      end else begin
         imem_if.valid = 1'b0;
         imem_if.rdata = 32'hDEAD_BEEF;
         if (pend) pend_cnt--;
      end
      imem_if2.valid = last_req2;
      imem_if2.rdata = word_at(last_addr2);
      #1;
      s_req     = imem_if.req;
      s_addr    = imem_if.addr;
      s_ivalid  = instr_valid;
      s_instr   = instr;
      s_ipc     = instr_pc;
      s2_ivalid = instr_valid2;
      s2_instr  = instr2;
      s2_ipc    = instr_pc2;
      if (imem_if.req) begin
         if (pend) proto_err = 1'b1;
         pend      = 1'b1;
         pend_addr = imem_if.addr;
         pend_cnt  = mem_lat - 1;
      end
      last_req2  = imem_if2.req;
      last_addr2 = imem_if2.addr;
      if (imem_if2.req) q2.push_back(imem_if2.addr);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
      drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
      pend      = 1'b0;
      last_req2 = 1'b0;
      q2.delete();
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
         n_checks++;
         if (s_req !== 1'b0 || s_ivalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl c=%0d req=%b ivalid=%b want 0 0", c, s_req, s_ivalid);
         end
         n_checks++;
         if (s_instr !== NOP_INSTR) begin
            n_fail++;
            $display("FAIL reset_instr got %h want %h", s_instr, NOP_INSTR);
         end
         n_checks++;
         if (s_ipc !== 32'd0 || s_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_pc ipc=%h addr=%h want 0 0", s_ipc, s_addr);
         end
      end
      pend      = 1'b0;
      last_req2 = 1'b0;
      q2.delete();
   endtask

   task automatic test_sequential();
      logic [31:0] ea;
      mem_lat = 1;
      for (int c = 0; c < 8; c++) begin
         drive_cycle(1'b0, 1'b0, 32'd0, 1'b0);
         n_checks++;
         if (s_req !== ((c % 2) == 0)) begin
            n_fail++;
            $display("FAIL seq_req c=%0d got %b", c, s_req);
         end
         if ((c % 2) == 0) begin
            ea = 32'(c / 2) * INCR;
            n_checks++;
            if (s_addr !== ea) begin
               n_fail++;
               $display("FAIL seq_addr c=%0d got %h want %h", c, s_addr, ea);
            end
         end
         n_checks++;
         if (s_ivalid !== (c >= 2 && (c % 2) == 0)) begin
            n_fail++;
            $display("FAIL seq_ivalid c=%0d got %b", c, s_ivalid);
         end
         if (c >= 2 && (c % 2) == 0) begin
            ea = 32'(c / 2 - 1) * INCR;
            n_checks++;
            if (s_ipc !== ea || s_instr !== word_at(ea)) begin
               n_fail++;
               $display("FAIL seq_instr c=%0d pc=%h instr=%h want %h %h", c, s_ipc, s_instr, ea, word_at(ea));
            end
         end
      end
   endtask

   task automatic test_stall_skid();
      do_reset();
      mem_lat = 1;
      for (int c = 0; c < 11; c++) begin
         drive_cycle((c >= 2 && c <= 6), 1'b0, 32'd0, 1'b0);
         if (c >= 2 && c <= 7) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'd0 || s_instr !== word_at(32'd0)) begin
               n_fail++;
               $display("FAIL stall_frozen c=%0d v=%b pc=%h instr=%h", c, s_ivalid, s_ipc, s_instr);
            end
         end
         if (c >= 3 && c <= 7) begin
            n_checks++;
            if (s_req !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_noreq c=%0d req=%b want 0", c, s_req);
            end
         end
         if (c == 8) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'd4 || s_instr !== word_at(32'd4)) begin
               n_fail++;
               $display("FAIL skid_out v=%b pc=%h instr=%h want 1 4 %h", s_ivalid, s_ipc, s_instr, word_at(32'd4));
            end
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'd8) begin
               n_fail++;
               $display("FAIL skid_next_req req=%b addr=%h want 1 8", s_req, s_addr);
            end
         end
         if (c == 9) begin
            n_checks++;
            if (s_ivalid !== 1'b0) begin
               n_fail++;
               $display("FAIL skid_dup v=%b want 0", s_ivalid);
            end
         end
         if (c == 10) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'd8) begin
               n_fail++;
               $display("FAIL skid_after v=%b pc=%h want 1 8", s_ivalid, s_ipc);
            end
         end
      end
   endtask

   task automatic test_redirect_kill();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         mem_lat = (c < 5) ? 4 : 1;
         drive_cycle(1'b0, (c == 1), 32'h100, 1'b0);
         if (c >= 2 && c <= 4) begin
            n_checks++;
            if (s_req !== 1'b0) begin
               n_fail++;
               $display("FAIL kill_noreq c=%0d req=%b want 0", c, s_req);
            end
         end
         if (c >= 2 && c <= 6) begin
            n_checks++;
            if (s_ivalid !== 1'b0 || s_instr !== NOP_INSTR) begin
               n_fail++;
               $display("FAIL kill_out c=%0d v=%b instr=%h want 0 %h", c, s_ivalid, s_instr, NOP_INSTR);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h100) begin
               n_fail++;
               $display("FAIL kill_addr req=%b addr=%h want 1 100", s_req, s_addr);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'h100 || s_instr !== word_at(32'h100)) begin
               n_fail++;
               $display("FAIL kill_deliver v=%b pc=%h instr=%h", s_ivalid, s_ipc, s_instr);
            end
`ifdef FETCH_PERF_CNT_EN
            n_checks++;
            if (perf_k !== 32'd1 || perf_f !== 32'd1) begin
               n_fail++;
               $display("FAIL perf_cnt killed=%0d fetched=%0d want 1 1", perf_k, perf_f);
            end
`endif
         end
      end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      mem_lat = 1;
      for (int c = 0; c < 6; c++) begin
         drive_cycle((c == 2), (c == 2), 32'h200, 1'b0);
         if (c == 2) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'd0) begin
               n_fail++;
               $display("FAIL rs_pre v=%b pc=%h want 1 0", s_ivalid, s_ipc);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (s_ivalid !== 1'b0 || s_instr !== 32'hFC00_0000 || op_field(s_instr) !== 6'b111111) begin
               n_fail++;
               $display("FAIL rs_nop v=%b instr=%h want 0 fc000000", s_ivalid, s_instr);
            end
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h200) begin
               n_fail++;
               $display("FAIL rs_addr req=%b addr=%h want 1 200", s_req, s_addr);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'h200 || s_instr !== word_at(32'h200)) begin
               n_fail++;
               $display("FAIL rs_deliver v=%b pc=%h instr=%h", s_ivalid, s_ipc, s_instr);
            end
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      mem_lat = 1;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(1'b0, 1'b0, 32'd0, 1'b0);
         if (c == 2) begin
            n_checks++;
            if (s2_ivalid !== 1'b1 || s2_ipc !== 32'hFFFF_FFFC || s2_instr !== word_at(32'hFFFF_FFFC)) begin
               n_fail++;
               $display("FAIL wrap_first v=%b pc=%h instr=%h", s2_ivalid, s2_ipc, s2_instr);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (s2_ivalid !== 1'b1 || s2_ipc !== 32'd0) begin
               n_fail++;
               $display("FAIL wrap_second v=%b pc=%h want 1 0", s2_ivalid, s2_ipc);
            end
         end
      end
      n_checks++;
      if (q2.size() < 2) begin
         n_fail++;
         $display("FAIL wrap_reqs got %0d requests want >=2", q2.size());
      end else if (q2[0] !== 32'hFFFF_FFFC || q2[1] !== 32'd0) begin
         n_fail++;
         $display("FAIL wrap_addr got %h %h want fffffffc 0", q2[0], q2[1]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         mem_lat = (c == 4) ? 2 : 1;
         drive_cycle(1'b0, 1'b0, 32'd0, (c == 5));
         if (c == 5) begin
            n_checks++;
            if (s_req !== 1'b0 || s_ivalid !== 1'b0 || s_addr !== 32'd0) begin
               n_fail++;
               $display("FAIL rmid_rst req=%b v=%b addr=%h want 0 0 0", s_req, s_ivalid, s_addr);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'd0) begin
               n_fail++;
               $display("FAIL rmid_restart req=%b addr=%h want 1 0", s_req, s_addr);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (s_ivalid !== 1'b0) begin
               n_fail++;
               $display("FAIL rmid_stale v=%b want 0", s_ivalid);
            end
         end
         if (c == 8) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_ipc !== 32'd0 || s_instr !== word_at(32'd0)) begin
               n_fail++;
               $display("FAIL rmid_first v=%b pc=%h instr=%h want 1 0 %h", s_ivalid, s_ipc, s_instr, word_at(32'd0));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, p_instr, p_ipc, rpc;
      bit          prev_hold, prev_redir, st, rd;
      int          delivered;
      do_reset();
      exp_pc     = 32'd0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
      p_instr    = '0;
      p_ipc      = '0;
      delivered  = 0;
      for (int c = 0; c < 3000; c++) begin
         st      = ($urandom_range(0, 9) < 4);
         rd      = ($urandom_range(0, 24) == 0);
         rpc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
         mem_lat = $urandom_range(1, 4);
         drive_cycle(st, rd, rpc, 1'b0);
         n_checks++;
         if (proto_err) begin
            n_fail++;
            $display("FAIL rnd_outstanding c=%0d second request while one pending", c);
         end
         n_checks++;
         if (s_ivalid === 1'b0 && s_instr !== NOP_INSTR) begin
            n_fail++;
            $display("FAIL rnd_nop c=%0d instr=%h want %h", c, s_instr, NOP_INSTR);
         end
         if (prev_hold) begin
            n_checks++;
            if (s_ivalid !== 1'b1 || s_instr !== p_instr || s_ipc !== p_ipc) begin
               n_fail++;
               $display("FAIL rnd_hold c=%0d v=%b pc=%h instr=%h want 1 %h %h", c, s_ivalid, s_ipc, s_instr, p_ipc, p_instr);
            end
         end
         if (prev_redir) begin
            n_checks++;
            if (s_ivalid !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_redir_flush c=%0d v=%b want 0", c, s_ivalid);
            end
         end
         if (s_ivalid === 1'b1 && !st && !rd) begin
            n_checks++;
            if (s_ipc !== exp_pc || s_instr !== word_at(exp_pc)) begin
               n_fail++;
               $display("FAIL rnd_stream c=%0d pc=%h instr=%h want %h %h", c, s_ipc, s_instr, exp_pc, word_at(exp_pc));
               exp_pc = s_ipc;
            end
            exp_pc = exp_pc + INCR;
            delivered++;
         end
         if (rd) exp_pc = rpc;
         prev_hold  = (s_ivalid === 1'b1) && st && !rd;
         prev_redir = rd;
         p_instr    = s_instr;
         p_ipc      = s_ipc;
      end
      n_checks++;
      if (delivered < 100) begin
         n_fail++;
         $display("FAIL rnd_progress delivered=%0d want >=100", delivered);
      end
   endtask

   initial begin
      rst            = 1'b1;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_if.valid  = 1'b0;
      imem_if.rdata  = '0;
      imem_if2.valid = 1'b0;
      imem_if2.rdata = '0;
      pend           = 1'b0;
      pend_cnt       = 0;
      pend_addr      = '0;
      mem_lat        = 1;
      last_req2      = 1'b0;
      last_addr2     = '0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall_skid();
      test_redirect_kill();
      test_redirect_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
